// File: rtl/palette_pkg.sv
// Shared palette constants: default 8-entry colour table and channel-width scaling.
package palette_pkg;

  localparam int unsigned DEF_CH_W    = 8;
  localparam int unsigned DEF_ENTRIES = 8;
  localparam int unsigned MAX_CH_W    = 16;
  localparam int unsigned MAX_RGB_W   = 3 * MAX_CH_W;

  // Reset contents, 8 bits per channel, R in the MSBs
  localparam logic [23:0] DEF_TABLE [DEF_ENTRIES] = '{
    24'hAAAAAA, 24'h000000, 24'hD2B48C, 24'hFFE4B5,
    24'hFFFFFF, 24'hFF4500, 24'hADFF2F, 24'hAAAAAA
  };

  // Default colour for any index; entries past the table are black
  function automatic logic [23:0] default_rgb(input int unsigned idx);
    logic [23:0] res;
    res = '0;
    if (idx < DEF_ENTRIES) res = DEF_TABLE[idx[2:0]];
    return res;
  endfunction

  // Rescale an 8-bit/channel colour to ch_w bits/channel (MSB aligned), packed in the LSBs
  function automatic logic [MAX_RGB_W-1:0] scale_rgb(input logic [23:0] c,
                                                     input int unsigned ch_w);
    logic [MAX_CH_W-1:0]  r;
    logic [MAX_CH_W-1:0]  g;
    logic [MAX_CH_W-1:0]  b;
    logic [MAX_RGB_W-1:0] res;
    r = MAX_CH_W'(c[23:16]);
    g = MAX_CH_W'(c[15:8]);
    b = MAX_CH_W'(c[7:0]);
    if (ch_w >= DEF_CH_W) begin
      r = r << (ch_w - DEF_CH_W);
      g = g << (ch_w - DEF_CH_W);
      b = b << (ch_w - DEF_CH_W);
    end else begin
      r = r >> (DEF_CH_W - ch_w);
      g = g >> (DEF_CH_W - ch_w);
      b = b >> (DEF_CH_W - ch_w);
    end
    res = (MAX_RGB_W'(r) << (2 * ch_w)) | (MAX_RGB_W'(g) << ch_w) | MAX_RGB_W'(b);
    return res;
  endfunction

endpackage

// File: rtl/palette_lut_if.sv
// Pixel lookup, palette write and bank-swap signals of palette_lut.
interface palette_lut_if #(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CH_W  = 8
);
  localparam int unsigned RGB_W = 3 * CH_W;

  logic             pix_valid;
  logic [IDX_W-1:0] pix_idx;
  logic             pix_blank;
  logic             frame_start;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [RGB_W-1:0] wr_rgb;
  logic             swap_req;
  logic             rgb_valid;
  logic [RGB_W-1:0] rgb;
  logic             swap_pending;
  logic             active_bank;

  modport master (
    output pix_valid, pix_idx, pix_blank, frame_start,
    output wr_en, wr_idx, wr_rgb, swap_req,
    input  rgb_valid, rgb, swap_pending, active_bank
  );

  modport slave (
    input  pix_valid, pix_idx, pix_blank, frame_start,
    input  wr_en, wr_idx, wr_rgb, swap_req,
    output rgb_valid, rgb, swap_pending, active_bank
  );

endinterface

// File: rtl/palette_bank.sv
// One palette bank: register array with synchronous write, combinational read,
// and reset load of the default colour table.
module palette_bank
  import palette_pkg::*;
#(
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CH_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [3*CH_W-1:0]  wr_rgb,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [3*CH_W-1:0]  rd_rgb_c
);

  localparam int unsigned RGB_W = 3 * CH_W;
  localparam int unsigned DEPTH = 1 << IDX_W;

  logic [RGB_W-1:0] mem [DEPTH];

  // Reset reloads every entry; otherwise one entry written per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= RGB_W'(scale_rgb(default_rgb(i), CH_W));
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_rgb;
    end
  end

  assign rd_rgb_c = mem[rd_idx];

endmodule

// File: rtl/palette_lut.sv
// Double-buffered colour palette: two-stage lookup from the active bank, writes to
// the shadow bank, bank swap deferred to the next frame start.
module palette_lut
  import palette_pkg::*;
#(
  parameter int unsigned IDX_W = 3,  // 1..8
  parameter int unsigned CH_W  = 8   // 1..MAX_CH_W
) (
  input  logic          clk,
  input  logic          rst,
  palette_lut_if.slave  bus
);

  localparam int unsigned RGB_W = 3 * CH_W;

  logic             active_bank_q;
  logic             swap_pending_q;
  logic             s1_valid_q;
  logic             s1_blank_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic             rgb_valid_q;
  logic [RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0] bank_rd_c [2];
  logic [RGB_W-1:0] lookup_c;

  // Bank b is the shadow (writable) bank whenever it is not active
  for (genvar b = 0; b < 2; b++) begin : g_bank
    palette_bank #(
      .IDX_W (IDX_W),
      .CH_W  (CH_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (bus.wr_en && (active_bank_q != 1'(b))),
      .wr_idx   (bus.wr_idx),
      .wr_rgb   (bus.wr_rgb),
      .rd_idx   (s1_idx_q),
      .rd_rgb_c (bank_rd_c[b])
    );
  end

  // Read uses the bank active during stage 1, so a swap landing then applies to that pixel
  assign lookup_c = bank_rd_c[active_bank_q];

  // Swap request is latched, then performed only at a frame start
  always_ff @(posedge clk) begin
    if (rst) begin
      active_bank_q  <= 1'b0;
      swap_pending_q <= 1'b0;
    end else if (bus.frame_start && swap_pending_q) begin
      active_bank_q  <= ~active_bank_q;
      swap_pending_q <= 1'b0;
    end else if (bus.swap_req) begin
      swap_pending_q <= 1'b1;
    end
  end

  // Two-stage lookup pipeline; blanked or idle slots output black
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_blank_q  <= 1'b0;
      s1_idx_q    <= '0;
      rgb_valid_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      s1_valid_q  <= bus.pix_valid;
      s1_blank_q  <= bus.pix_blank;
      s1_idx_q    <= bus.pix_idx;
      rgb_valid_q <= s1_valid_q;
      rgb_q       <= (s1_valid_q && !s1_blank_q) ? lookup_c : '0;
    end
  end

  assign bus.rgb_valid    = rgb_valid_q;
  assign bus.rgb          = rgb_q;
  assign bus.swap_pending = swap_pending_q;
  assign bus.active_bank  = active_bank_q;

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: default table, bank swapping, blanking, reset,
// and a narrow-channel / deep-index configuration.
module tb_palette_lut;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  palette_lut_if #(.IDX_W(3), .CH_W(8)) bus ();
  palette_lut_if #(.IDX_W(4), .CH_W(4)) bus4 ();

  palette_lut #(.IDX_W(3), .CH_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  palette_lut #(.IDX_W(4), .CH_W(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pix_valid = 1'b0;  bus.pix_idx = '0;  bus.pix_blank = 1'b0;
    bus.frame_start = 1'b0; bus.wr_en = 1'b0; bus.wr_idx = '0;
    bus.wr_rgb = '0;       bus.swap_req = 1'b0;
    bus4.pix_valid = 1'b0; bus4.pix_idx = '0; bus4.pix_blank = 1'b0;
    bus4.frame_start = 1'b0; bus4.wr_en = 1'b0; bus4.wr_idx = '0;
    bus4.wr_rgb = '0;      bus4.swap_req = 1'b0;
  endtask

  // Single isolated lookup on the 8-bit instance; returns what appears two cycles later
  task automatic lookup(input logic [2:0] idx, input logic blank,
                        output logic v, output logic [23:0] c);
    bus.pix_valid = 1'b1;
    bus.pix_idx   = idx;
    bus.pix_blank = blank;
    tick();
    bus.pix_valid = 1'b0;
    bus.pix_blank = 1'b0;
    tick();
    v = bus.rgb_valid;
    c = bus.rgb;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.rgb_valid !== 1'b0) begin n_err++; $display("FAIL reset_rgb_valid: got %b expected 0", bus.rgb_valid); end
    n_cmp++;
    if (bus.rgb !== 24'h000000) begin n_err++; $display("FAIL reset_rgb: got %h expected 000000", bus.rgb); end
    n_cmp++;
    if (bus.active_bank !== 1'b0) begin n_err++; $display("FAIL reset_active_bank: got %b expected 0", bus.active_bank); end
    n_cmp++;
    if (bus.swap_pending !== 1'b0) begin n_err++; $display("FAIL reset_swap_pending: got %b expected 0", bus.swap_pending); end
    n_cmp++;
    if (bus4.rgb_valid !== 1'b0) begin n_err++; $display("FAIL reset_rgb_valid_w4: got %b expected 0", bus4.rgb_valid); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_tab [8];
    exp_tab = '{24'hAAAAAA, 24'h000000, 24'hD2B48C, 24'hFFE4B5,
                24'hFFFFFF, 24'hFF4500, 24'hADFF2F, 24'hAAAAAA};
    for (int i = 0; i <= 8; i++) begin
      bus.pix_valid = (i < 8);
      bus.pix_idx   = 3'(i);
      tick();
      if (i == 0) begin
        n_cmp++;
        if (bus.rgb_valid !== 1'b0) begin n_err++; $display("FAIL b2b_latency: got rgb_valid %b expected 0 after one cycle", bus.rgb_valid); end
      end else begin
        n_cmp++;
        if (bus.rgb_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid idx%0d: got %b expected 1", i - 1, bus.rgb_valid); end
        n_cmp++;
        if (bus.rgb !== exp_tab[i-1]) begin n_err++; $display("FAIL b2b_rgb idx%0d: got %h expected %h", i - 1, bus.rgb, exp_tab[i-1]); end
      end
    end
    tick();
    n_cmp++;
    if (bus.rgb_valid !== 1'b0 || bus.rgb !== 24'h000000) begin
      n_err++; $display("FAIL b2b_drain: got valid %b rgb %h expected 0 000000", bus.rgb_valid, bus.rgb);
    end
  endtask

  task automatic test_swap_write();
    logic v;
    logic [23:0] c;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_rgb = 24'h123456;
    tick();
    bus.wr_en = 1'b0;
    lookup(3'd3, 1'b0, v, c);
    n_cmp++;
    if (c !== 24'hFFE4B5) begin n_err++; $display("FAIL shadow_write_isolated: got %h expected FFE4B5", c); end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    n_cmp++;
    if (bus.swap_pending !== 1'b1 || bus.active_bank !== 1'b0) begin
      n_err++; $display("FAIL swap_req_pending: got pending %b bank %b expected 1 0", bus.swap_pending, bus.active_bank);
    end
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    n_cmp++;
    if (bus.active_bank !== 1'b1 || bus.swap_pending !== 1'b0) begin
      n_err++; $display("FAIL swap_done: got bank %b pending %b expected 1 0", bus.active_bank, bus.swap_pending);
    end
    lookup(3'd3, 1'b0, v, c);
    n_cmp++;
    if (v !== 1'b1 || c !== 24'h123456) begin n_err++; $display("FAIL post_swap_lookup: got %b %h expected 1 123456", v, c); end
  endtask

  task automatic test_blank();
    logic v;
    logic [23:0] c;
    lookup(3'd5, 1'b1, v, c);
    n_cmp++;
    if (v !== 1'b1 || c !== 24'h000000) begin n_err++; $display("FAIL blank_lookup: got %b %h expected 1 000000", v, c); end
    tick();
    n_cmp++;
    if (bus.rgb_valid !== 1'b0 || bus.rgb !== 24'h000000) begin
      n_err++; $display("FAIL idle_output: got %b %h expected 0 000000", bus.rgb_valid, bus.rgb);
    end
  endtask

  task automatic test_same_cycle_swap();
    // active bank is 1 on entry
    bus.swap_req = 1'b1; bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    n_cmp++;
    if (bus.active_bank !== 1'b1 || bus.swap_pending !== 1'b1) begin
      n_err++; $display("FAIL same_cycle_defer: got bank %b pending %b expected 1 1", bus.active_bank, bus.swap_pending);
    end
    tick();
    n_cmp++;
    if (bus.active_bank !== 1'b1 || bus.swap_pending !== 1'b1) begin
      n_err++; $display("FAIL repeat_req: got bank %b pending %b expected 1 1", bus.active_bank, bus.swap_pending);
    end
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0; bus.swap_req = 1'b0;
    n_cmp++;
    if (bus.active_bank !== 1'b0 || bus.swap_pending !== 1'b0) begin
      n_err++; $display("FAIL req_absorbed: got bank %b pending %b expected 0 0", bus.active_bank, bus.swap_pending);
    end
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    n_cmp++;
    if (bus.active_bank !== 1'b0 || bus.swap_pending !== 1'b0) begin
      n_err++; $display("FAIL frame_no_pending: got bank %b pending %b expected 0 0", bus.active_bank, bus.swap_pending);
    end
  endtask

  task automatic test_write_in_swap();
    logic v;
    logic [23:0] c;
    // active bank 0; bank 1 already holds 123456 at idx3
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.frame_start = 1'b1;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd1; bus.wr_rgb = 24'h00FF00;
    tick();
    bus.frame_start = 1'b0; bus.wr_en = 1'b0;
    n_cmp++;
    if (bus.active_bank !== 1'b1) begin n_err++; $display("FAIL swap_with_write_bank: got %b expected 1", bus.active_bank); end
    lookup(3'd1, 1'b0, v, c);
    n_cmp++;
    if (c !== 24'h00FF00) begin n_err++; $display("FAIL write_in_swap: got %h expected 00FF00", c); end
    lookup(3'd3, 1'b0, v, c);
    n_cmp++;
    if (c !== 24'h123456) begin n_err++; $display("FAIL shadow_retained: got %h expected 123456", c); end
    lookup(3'd0, 1'b0, v, c);
    n_cmp++;
    if (c !== 24'hAAAAAA) begin n_err++; $display("FAIL untouched_entry: got %h expected AAAAAA", c); end
  endtask

  task automatic test_swap_timing();
    // active bank 1; pixel issued with the swapping frame_start reads the new bank 0
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.frame_start = 1'b1;
    bus.pix_valid = 1'b1; bus.pix_idx = 3'd3;
    tick();
    bus.frame_start = 1'b0; bus.pix_valid = 1'b0;
    tick();
    n_cmp++;
    if (bus.rgb_valid !== 1'b1 || bus.rgb !== 24'hFFE4B5) begin
      n_err++; $display("FAIL swap_stage1_bank: got %b %h expected 1 FFE4B5", bus.rgb_valid, bus.rgb);
    end
    n_cmp++;
    if (bus.active_bank !== 1'b0) begin n_err++; $display("FAIL swap_stage1_active: got %b expected 0", bus.active_bank); end
  endtask

  task automatic test_reset_midstream();
    logic v;
    logic [23:0] c;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0; bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    bus.pix_valid = 1'b1; bus.pix_idx = 3'd3;
    tick();
    rst = 1'b1;
    bus.wr_en = 1'b1; bus.wr_idx = 3'd3; bus.wr_rgb = 24'h777777;
    bus.swap_req = 1'b1; bus.frame_start = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    n_cmp++;
    if (bus.rgb_valid !== 1'b0 || bus.rgb !== 24'h000000) begin
      n_err++; $display("FAIL rst_mid_output: got %b %h expected 0 000000", bus.rgb_valid, bus.rgb);
    end
    n_cmp++;
    if (bus.active_bank !== 1'b0 || bus.swap_pending !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ctrl: got bank %b pending %b expected 0 0", bus.active_bank, bus.swap_pending);
    end
    tick();
    n_cmp++;
    if (bus.rgb_valid !== 1'b0 || bus.swap_pending !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_discard: got valid %b pending %b expected 0 0", bus.rgb_valid, bus.swap_pending);
    end
    lookup(3'd3, 1'b0, v, c);
    n_cmp++;
    if (v !== 1'b1 || c !== 24'hFFE4B5) begin n_err++; $display("FAIL rst_bank0_idx3: got %b %h expected 1 FFE4B5", v, c); end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0; bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
    lookup(3'd3, 1'b0, v, c);
    n_cmp++;
    if (c !== 24'hFFE4B5) begin n_err++; $display("FAIL rst_bank1_idx3: got %h expected FFE4B5", c); end
    lookup(3'd1, 1'b0, v, c);
    n_cmp++;
    if (c !== 24'h000000) begin n_err++; $display("FAIL rst_bank1_idx1: got %h expected 000000", c); end
  endtask

  task automatic test_wide_config();
    logic [11:0] exp4 [10];
    exp4 = '{12'hAAA, 12'h000, 12'hDB8, 12'hFEB, 12'hFFF,
             12'hF40, 12'hAF2, 12'hAAA, 12'h000, 12'h000};
    for (int i = 0; i <= 10; i++) begin
      bus4.pix_valid = (i < 10);
      bus4.pix_idx   = 4'(i);
      tick();
      if (i > 0) begin
        n_cmp++;
        if (bus4.rgb_valid !== 1'b1 || bus4.rgb !== exp4[i-1]) begin
          n_err++; $display("FAIL w4_rgb idx%0d: got %b %h expected 1 %h", i - 1, bus4.rgb_valid, bus4.rgb, exp4[i-1]);
        end
      end
    end
    tick();
    n_cmp++;
    if (bus4.rgb_valid !== 1'b0 || bus4.rgb !== 12'h000) begin
      n_err++; $display("FAIL w4_drain: got %b %h expected 0 000", bus4.rgb_valid, bus4.rgb);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_swap_write();
    test_blank();
    test_same_cycle_swap();
    test_write_in_swap();
    test_swap_timing();
    test_reset_midstream();
    test_wide_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/palette_lut.md
PALETTE_LUT -- requirements
Module: palette_lut

Interface
REQ-001 Parameter IDX_W, default 3, pixel/palette index width; depth = 2**IDX_W entries, legal range 1..8.
REQ-002 Parameter CH_W, default 8, bits per colour channel; RGB word = 3*CH_W, R in MSBs, B in LSBs.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pix_valid  in  1  pixel lookup request this cycle.
REQ-006 pix_idx  in  IDX_W  palette index of requested pixel.
REQ-007 pix_blank  in  1  pixel lies in blanking interval; output forced black.
REQ-008 frame_start  in  1  one-cycle pulse at start of each frame; only point where banks may swap.
REQ-009 wr_en  in  1  write one entry of the shadow bank.
REQ-010 wr_idx  in  IDX_W  entry to write.
REQ-011 wr_rgb  in  3*CH_W  colour to write.
REQ-012 swap_req  in  1  request to swap active/shadow banks at next frame_start.
REQ-013 rgb_valid  out  1  rgb carries a lookup result.
REQ-014 rgb  out  3*CH_W  looked-up colour.
REQ-015 swap_pending  out  1  swap requested, not yet performed.
REQ-016 active_bank  out  1  bank (0/1) currently used for lookups.

Function
REQ-017 Two banks of 2**IDX_W entries each, 3*CH_W bits; lookups read active bank only; writes target shadow bank (~active_bank) only.
REQ-018 Lookup latency exactly 2 cycles: pix_valid at cycle N -> rgb_valid high at N+2 with result; one result per cycle, no stalls, no backpressure.
REQ-019 rgb_valid low -> rgb held at 0.
REQ-020 pix_blank high with pix_valid -> rgb_valid high, rgb = 0 at N+2, regardless of entry content.
REQ-021 Bank read for a lookup uses active_bank as registered in the first pipeline stage (cycle N+1); swap at N+1 affects that pixel.
REQ-022 wr_en high -> shadow[wr_idx] = wr_rgb at next edge; active bank unaffected.
REQ-023 swap_req high -> swap_pending set next cycle; repeated requests while pending have no extra effect.
REQ-024 frame_start high while swap_pending high -> active_bank toggles and swap_pending clears at next edge; frame_start with no pending swap -> no change.
REQ-025 swap_req and frame_start same cycle, none pending -> swap NOT performed this frame; pending set, swap at following frame_start.
REQ-026 wr_en in swap cycle -> write lands in pre-swap shadow bank (the bank becoming active).
REQ-027 swap_pending and frame_start high, swap_req also high -> swap performed, swap_pending cleared (request absorbed).
REQ-028 No partial copy between banks on swap; new shadow keeps its old contents.

Reset
REQ-029 rst high at any edge: active_bank=0, swap_pending=0, pipeline valids cleared, rgb_valid=0, rgb=0; in-flight lookups discarded.
REQ-030 rst loads both banks: idx0 AAAAAA, idx1 000000, idx2 D2B48C, idx3 FFE4B5, idx4 FFFFFF, idx5 FF4500, idx6 ADFF2F, idx7 AAAAAA; idx>=8 zero; idx beyond depth dropped when IDX_W<3.
REQ-031 Default colours are 8-bit/channel; CH_W<8 takes channel MSBs, CH_W>8 MSB-aligned with zero LSBs.
REQ-032 rst overrides wr_en, swap_req, frame_start in same cycle.

Structure
REQ-033 Shared package palette_pkg holds default 8-entry colour table (8-bit/channel) and channel-scaling function.
REQ-034 One sub-module palette_bank (parametrised IDX_W, CH_W): register array, sync write, comb read, reset load from package table; instantiated twice.

Verification
REQ-035 Reset, then pix_valid idx 0..7 on consecutive cycles -> rgb_valid from cycle 2, rgb = AAAAAA,000000,D2B48C,FFE4B5,FFFFFF,FF4500,ADFF2F,AAAAAA back-to-back.
REQ-036 wr idx3=123456, lookup idx3 -> FFE4B5; swap_req, frame_start -> active_bank=1, swap_pending=0; lookup idx3 -> 123456.
REQ-037 pix_blank=1, idx5 -> rgb_valid=1, rgb=000000 at +2; pix_valid=0 -> rgb_valid=0, rgb=0.
REQ-038 swap_req and frame_start same cycle -> active_bank unchanged, swap_pending=1; next frame_start -> active_bank toggles.
REQ-039 wr_en idx1=00FF00 during swap cycle -> after swap lookup idx1 = 00FF00.
REQ-040 After writes and swap, rst mid-stream with pix_valid high -> next cycle rgb_valid=0, active_bank=0, idx3 lookup = FFE4B5; repeat REQ-035 with IDX_W=4, CH_W=4 (idx2 -> DB8, idx9 -> 000).
